karatsuba_div_8: RTL and testbench
==================================

# karatsuba_div_8

Sequential restoring divider: the inverse of the team's Karatsuba multiplier. Accepts an n-bit dividend C and an m-bit divisor B, returns an n-bit quotient Q and an m-bit remainder R, one quotient bit per clock. For any product C = A*B from the multiplier with B ≠ 0, it returns Q = A, R = 0. Used to check multiplier results and wherever the datapath needs a division at the same width.

## Interface
- m, 4, divisor and remainder width (same meaning as the multiplier's operand width)
- n, 8, dividend and quotient width; must equal 2*m
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  C/B valid
- in_ready  output  1  divider can accept an operand pair
- C  input  n  dividend, unsigned
- B  input  m  divisor, unsigned
- out_valid  output  1  Q/R/dbz valid
- out_ready  input  1  consumer accepts the result
- Q  output  n  quotient
- R  output  m  remainder
- dbz  output  1  divide-by-zero flag for the current result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - B≠0: load dividend shift register with C, remainder register with 0, divisor register with B, step counter with 0, then go to BUSY.
  - B=0: load Q=all ones, R=C[m-1:0], dbz=1, then go straight to DONE.
- BUSY: in_ready=0, and in_valid is ignored. Each cycle does one restoring step:
  - t = {rem, dividend MSB} (m+1 bits).
  - If t ≥ {1'b0, divisor}: rem ← t − divisor and shift a 1 into Q's LSB.
  - Otherwise: rem ← t[m-1:0] and shift in a 0.
  - Shift the dividend left by 1 and increment the counter.
  - After n steps, go to DONE with dbz=0.
- DONE: out_valid=1. Q, R and dbz are held stable until out_ready=1. On the out_ready edge, go to IDLE.
- Arithmetic:
  - Unsigned only.
  - The subtraction is m+1 bits wide, so it never overflows.
  - The counter is ceil(log2(n+1)) bits.
  - R < B always holds when dbz=0.
- A new operand pair is never accepted in the same cycle as a result is retired. Maximum throughput is one division per n+2 cycles.

## Timing
- Reset (asynchronous, any state, including mid-BUSY):
  - state=IDLE, in_ready=1 from the first cycle after deassertion.
  - out_valid=0, Q=0, R=0, dbz=0.
  - Any in-flight division is discarded and no result is produced.
- Acceptance at edge t0 with B≠0: BUSY during cycles t0..t0+n−1; out_valid=1 from edge t0+n. Latency is n+1 cycles from the cycle in_valid is presented.
- Acceptance at edge t0 with B=0: out_valid=1 from edge t0, one cycle later.
- out_ready high on the same edge that out_valid first rises: the result is retired on the following edge, so out_valid is high for at least one cycle.
- Q/R/dbz may change only in IDLE/BUSY. They are stable while out_valid=1.
- out_ready while not in DONE: ignored.

## Structure
- Shared package/header holds:
  - the state encoding (IDLE=0, BUSY=1, DONE=2, 2 bits)
  - the default M/N constants, shared with the multiplier
- One combinational sub-module, `div_step`: inputs rem (m), next dividend bit, divisor (m); outputs new rem (m) and quotient bit. It is instantiated once inside the sequential top.
- The top holds the FSM, counter, shift registers and handshake.

## Test plan
- C=143, B=13 (the multiplier product 11*13) → Q=11, R=0, dbz=0; out_valid rises exactly 9 cycles after the accepting cycle.
- C=200, B=15 → Q=13, R=5; C=255, B=1 → Q=255, R=0; C=0, B=9 → Q=0, R=0.
- C=7, B=0 → Q=255, R=7, dbz=1, with out_valid one cycle after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Q/R/dbz stay constant, in_ready stays 0, and in_valid pulses in that window are not accepted.
- Reset asserted asynchronously at step 4 of a division → out_valid=0, Q=R=0 immediately. A following C=100, B=7 → Q=14, R=2.
- Random sweep of all C and B≠0 for m=4 against C/B and C%B, with random in_valid/out_ready gaps; also cross-check against multiplier products, requiring Q=A and R=0.

Source files
------------

// File: rtl/karatsuba_div_8_pkg.sv
// Shared constants and state encoding for the restoring divider.
// M/N match the Karatsuba multiplier operand and product widths.
package karatsuba_div_8_pkg;

  localparam int M     = 4;
  localparam int N     = 2 * M;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/karatsuba_div_8_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface karatsuba_div_8_if;
  import karatsuba_div_8_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] C;
  logic [M-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         dbz;

  modport master (
    output in_valid, C, B, out_ready,
    input  in_ready, out_valid, Q, R, dbz
  );

  modport slave (
    input  in_valid, C, B, out_ready,
    output in_ready, out_valid, Q, R, dbz
  );

endinterface

// File: rtl/karatsuba_div_8_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module karatsuba_div_8_div_step
  import karatsuba_div_8_pkg::*;
(
  input  logic [M-1:0] rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] div_i,
  output logic [M-1:0] rem_o,
  output logic         q_o
);

  logic [M:0] t;
  logic [M:0] d;

  // One extra bit keeps the trial subtraction from overflowing.
  assign t     = {rem_i, bit_i};
  assign d     = {1'b0, div_i};
  assign q_o   = (t >= d);
  assign rem_o = q_o ? M'(t - d) : t[M-1:0];

endmodule

// File: rtl/karatsuba_div_8.sv
// Sequential restoring divider, one quotient bit per clock, with valid/ready handshake.
module karatsuba_div_8
  import karatsuba_div_8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  karatsuba_div_8_if.slave   bus
);

  state_e           state_q, state_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [M-1:0]     rem_q, rem_d;
  logic [M-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [M-1:0]     step_rem;
  logic             step_bit;

  // The dividend register doubles as the quotient: its MSB feeds the step, quotient bits enter the LSB.
  karatsuba_div_8_div_step u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[N-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Q         = quo_q;
  assign bus.R         = rem_q;
  assign bus.dbz       = dbz_q;

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path leaves it unassigned (no latch).
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.B != '0) begin
            quo_d   = bus.C;
            rem_d   = '0;
            div_d   = bus.B;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = BUSY;
          end else begin
            quo_d   = '1;
            rem_d   = bus.C[M-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        quo_d = {quo_q[N-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_karatsuba_div_8.sv
// Directed and swept checks of the restoring divider against hand-computed results.
module tb_karatsuba_div_8;
  import karatsuba_div_8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  karatsuba_div_8_if bus ();

  karatsuba_div_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present one operand pair, wait for the result, then retire it after ready_gap cycles.
  // lat counts rising edges from the presenting cycle (acceptance edge = 1) until out_valid.
  task automatic run_div(input logic [7:0] c, input logic [3:0] b, input int ready_gap,
                         output logic [7:0] q, output logic [3:0] r, output logic z,
                         output int lat, output bit timeout);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.C = c;
    bus.B = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    timeout = !bus.out_valid || (w >= 50);
    q = bus.Q;
    r = bus.R;
    z = bus.dbz;
    repeat (ready_gap) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    total++;
    if ({bus.Q, bus.R, bus.dbz} !== 13'd0)
      $display("FAIL reset_outputs: got Q=%0d R=%0d dbz=%b want 0/0/0", bus.Q, bus.R, bus.dbz);
    else passed++;
  endtask

  task automatic test_directed();
    logic [7:0] cv[5] = '{8'd143, 8'd200, 8'd255, 8'd0, 8'd7};
    logic [3:0] bv[5] = '{4'd13, 4'd15, 4'd1, 4'd9, 4'd0};
    logic [7:0] qv[5] = '{8'd11, 8'd13, 8'd255, 8'd0, 8'd255};
    logic [3:0] rv[5] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd7};
    logic       zv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         lv[5] = '{9, 9, 9, 9, 1};
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    bit         to;
    for (int i = 0; i < 5; i++) begin
      run_div(cv[i], bv[i], 0, q, r, z, lat, to);
      total++;
      if (to) $display("FAIL directed_timeout: C=%0d B=%0d got no out_valid want out_valid", cv[i], bv[i]);
      else passed++;
      total++;
      if ({q, r, z} !== {qv[i], rv[i], zv[i]})
        $display("FAIL directed_result C=%0d B=%0d: got Q=%0d R=%0d dbz=%b want Q=%0d R=%0d dbz=%b",
                 cv[i], bv[i], q, r, z, qv[i], rv[i], zv[i]);
      else passed++;
      total++;
      if (lat !== lv[i]) $display("FAIL directed_latency C=%0d B=%0d: got %0d want %0d", cv[i], bv[i], lat, lv[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.C = 8'd200;
    bus.B = 4'd15;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!bus.out_valid) $display("FAIL bp_timeout: got out_valid=0 want 1");
    else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.C = 8'd50;
      bus.B = 4'd3;
      @(negedge clk);
      total++;
      if ({bus.Q, bus.R, bus.dbz, bus.in_ready, bus.out_valid} !== {8'd13, 4'd5, 1'b0, 1'b0, 1'b1})
        $display("FAIL bp_hold cycle %0d: got Q=%0d R=%0d dbz=%b in_ready=%b out_valid=%b want 13/5/0/0/1",
                 i, bus.Q, bus.R, bus.dbz, bus.in_ready, bus.out_valid);
      else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL bp_retire: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    bit         to;
    bit         spurious;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.C = 8'd143;
    bus.B = 4'd13;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.Q, bus.R, bus.in_ready} !== {1'b0, 8'd0, 4'd0, 1'b1})
      $display("FAIL midreset_async: got out_valid=%b Q=%0d R=%0d in_ready=%b want 0/0/0/1",
               bus.out_valid, bus.Q, bus.R, bus.in_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) spurious = 1'b1;
    end
    total++;
    if (spurious) $display("FAIL midreset_no_result: got out_valid=1 want 0");
    else passed++;
    run_div(8'd100, 4'd7, 1, q, r, z, lat, to);
    total++;
    if (to || {q, r, z} !== {8'd14, 4'd2, 1'b0})
      $display("FAIL midreset_next: got Q=%0d R=%0d dbz=%b timeout=%b want 14/2/0/0", q, r, z, to);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    bit         to;
    int         fails;
    fails = 0;
    for (int c = 0; c < 256; c++) begin
      for (int b = 1; b < 16; b++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        run_div(8'(c), 4'(b), $urandom_range(0, 1), q, r, z, lat, to);
        total++;
        if (to || {q, r, z} !== {8'(c / b), 4'(c % b), 1'b0}) begin
          if (fails < 10)
            $display("FAIL sweep C=%0d B=%0d: got Q=%0d R=%0d dbz=%b timeout=%b want Q=%0d R=%0d dbz=0",
                     c, b, q, r, z, to, c / b, c % b);
          fails++;
        end else passed++;
      end
    end
  endtask

  task automatic test_products();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    bit         to;
    int         fails;
    fails = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(8'(a * b), 4'(b), 0, q, r, z, lat, to);
        total++;
        if (to || {q, r, z} !== {8'(a), 4'd0, 1'b0}) begin
          if (fails < 10)
            $display("FAIL product A=%0d B=%0d: got Q=%0d R=%0d dbz=%b want Q=%0d R=0 dbz=0",
                     a, b, q, r, z, a);
          fails++;
        end else passed++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.C         = '0;
    bus.B         = '0;
    rst           = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_products();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
